// File: rtl/ahfp_mult_pipe.sv
// ahfp_mult_pipe: pipelined IEEE-754-style multiplier, RNE rounding, flush-to-zero
//   clk, reset (async, active-high), clk_en (advance enable, low = full stall),
//   start/dataa/datab (operation issue), result/done (registered product and valid).
module ahfp_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   done
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam int M  = STAGES - 2;
    localparam int SW = 5 + EW + PW;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
    logic signed [EW-1:0] e_c;
    logic v1, s1, nan1, inf1, zero1;
    logic signed [EW-1:0] e1;
    logic [MW-1:0] ma1, mb1;
    logic [PW-1:0] prod;
    logic [SW-1:0] m0, mq;
    logic vq, sq, nanq, infq, zeroq;
    logic signed [EW-1:0] eq, ef;
    logic [PW-1:0] pq;
    logic hi, g, st;
    logic [MAN_W-1:0] mant;
    logic [MAN_W:0] mr;
    logic [W-1:0] res_c;
    assign {ea, fa} = dataa[W-2:0];
    assign {eb, fb} = datab[W-2:0];
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = &ea & ~|fa;
    assign b_inf  = &eb & ~|fb;
    assign a_nan  = &ea & |fa;
    assign b_nan  = &eb & |fb;
    assign e_c    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    // Stage 1: classify and add exponents; subnormals count as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {v1, s1, nan1, inf1, zero1} <= '0;
            e1  <= '0;
            ma1 <= '0;
            mb1 <= '0;
        end else if (clk_en) begin
            v1    <= start;
            s1    <= dataa[W-1] ^ datab[W-1];
            nan1  <= a_nan | b_nan | (a_zero & b_inf) | (b_zero & a_inf);
            inf1  <= a_inf | b_inf;
            zero1 <= a_zero | b_zero;
            e1    <= e_c;
            ma1   <= {1'b1, fa};
            mb1   <= {1'b1, fb};
        end
    end
    assign prod = PW'(ma1) * PW'(mb1);
    assign m0   = {v1, s1, nan1, inf1, zero1, e1, prod};
    // Extra latency goes into register slices behind the multiplier.
    generate
        if (M == 0) begin : g_comb
            assign mq = m0;
        end else begin : g_reg
            logic [SW-1:0] sl [1:M];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 1; k <= M; k++) sl[k] <= '0;
                end else if (clk_en) begin
                    sl[1] <= m0;
                    for (int k = 2; k <= M; k++) sl[k] <= sl[k-1];
                end
            end
            assign mq = sl[M];
        end
    endgenerate
    assign {vq, sq, nanq, infq, zeroq, eq, pq} = mq;
    // Product lies in [1,4): hi selects the one-position normalisation.
    always_comb begin
        hi    = pq[PW-1];
        mant  = hi ? pq[PW-2 -: MAN_W] : pq[PW-3 -: MAN_W];
        g     = hi ? pq[PW-2-MAN_W] : pq[PW-3-MAN_W];
        st    = hi ? |pq[PW-3-MAN_W:0] : |pq[PW-4-MAN_W:0];
        mr    = {1'b0, mant} + MW'(g & (st | mant[0]));
        ef    = eq + EW'(hi) + EW'(mr[MAN_W]);
        res_c = nanq ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                infq ? {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                zeroq ? {sq, {(W-1){1'b0}}} :
                (ef >= EMAX) ? {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                (ef <= 0) ? {sq, {(W-1){1'b0}}} :
                {sq, ef[EXP_W-1:0], mr[MAN_W-1:0]};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
        end else if (clk_en) begin
            done <= vq;
            if (vq) result <= res_c;
        end
    end
endmodule
